// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute controller driving PC_module strobes from fetched bytes.
// Define PC_SEQ_STACK_EN to add the CALL/RET return-address stack; otherwise 0x4/0x5 act as NOP.
module pc_sequencer #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       CLB,
  input  logic       run,
  input  logic [7:0] pc_count,
  input  logic [7:0] instr_in,
  input  logic       mem_ack,
  input  logic       zero_flag,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  output logic       SelPC,
  output logic       IncPC,
  output logic       LoadPC,
  output logic [7:0] A,
  output logic [3:0] B,
  output logic       exec_valid,
  output logic [7:0] exec_op,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPND,
    S_EXEC,
    S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] opnd_q, opnd_d;
  logic       zf_q, zf_d;
  logic [3:0] opcode;

  assign opcode = ir_q[7:4];

`ifdef PC_SEQ_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH);
  localparam logic [SP_W:0] CNT_FULL = (SP_W + 1)'(STACK_DEPTH);

  logic [7:0]      stk_q [STACK_DEPTH];
  logic [SP_W-1:0] wp_q;
  logic [SP_W:0]   cnt_q;
  logic [7:0]      stk_top;
  logic            do_push, do_pop;

  assign do_push = (state_q == S_EXEC) && (opcode == 4'h4);
  assign do_pop  = (state_q == S_EXEC) && (opcode == 4'h5);
  assign stk_top = (cnt_q == '0) ? 8'h00 : stk_q[wp_q - 1'b1];

  // Circular buffer: a push when full overwrites the oldest entry by wrapping wp_q.
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      wp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= 8'h00;
    end else if (do_push) begin
      stk_q[wp_q] <= pc_count + 8'd1;
      wp_q        <= wp_q + 1'b1;
      if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
    end else if (do_pop && (cnt_q != '0)) begin
      wp_q  <= wp_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end
`else
  localparam int unused_stack_depth = STACK_DEPTH;
`endif

  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state_q <= S_IDLE;
      ir_q    <= 8'h00;
      opnd_q  <= 8'h00;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
      zf_q    <= zf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    opnd_d     = opnd_q;
    zf_d       = zf_q;
    mem_req    = 1'b0;
    mem_addr   = 8'h00;
    SelPC      = 1'b0;
    IncPC      = 1'b0;
    LoadPC     = 1'b0;
    A          = 8'h00;
    B          = 4'h0;
    exec_valid = 1'b0;
    exec_op    = 8'h00;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_count;
        if (mem_ack) begin
          ir_d    = instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        zf_d = zero_flag;
        case (opcode)
          4'h1: begin
            IncPC   = 1'b1;
            state_d = S_OPND;
          end
`ifdef PC_SEQ_STACK_EN
          4'h4: begin
            IncPC   = 1'b1;
            state_d = S_OPND;
          end
`endif
          4'hF:    state_d = S_HALT;
          default: state_d = S_EXEC;
        endcase
      end
      S_OPND: begin
        mem_req  = 1'b1;
        mem_addr = pc_count;
        if (mem_ack) begin
          opnd_d  = instr_in;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = run ? S_FETCH : S_IDLE;
        case (opcode)
          4'h1: begin
            LoadPC = 1'b1;
            SelPC  = 1'b1;
            A      = opnd_q;
          end
`ifdef PC_SEQ_STACK_EN
          4'h4: begin
            LoadPC = 1'b1;
            SelPC  = 1'b1;
            A      = opnd_q;
          end
          4'h5: begin
            LoadPC = 1'b1;
            SelPC  = 1'b1;
            A      = stk_top;
          end
`endif
          4'h2: begin
            LoadPC = 1'b1;
            B      = ir_q[3:0];
          end
          4'h3: begin
            // Branch decision uses the flag captured in DECODE, not the live input.
            if (zf_q) begin
              LoadPC = 1'b1;
              B      = ir_q[3:0];
            end else begin
              IncPC = 1'b1;
            end
          end
          4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
            IncPC      = 1'b1;
            exec_valid = 1'b1;
            exec_op    = ir_q;
          end
          default: IncPC = 1'b1;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural memory and PC_module model.
// Build with PC_SEQ_STACK_EN defined to exercise the CALL/RET stack instead of the NOP fallback.
module tb_pc_sequencer;

  logic       CLK = 1'b0;
  logic       CLB = 1'b0;
  logic       run = 1'b0;
  logic [7:0] pc_count = 8'h00;
  logic [7:0] instr_in = 8'h00;
  logic       mem_ack = 1'b0;
  logic       zero_flag = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       SelPC, IncPC, LoadPC;
  logic [7:0] A;
  logic [3:0] B;
  logic       exec_valid;
  logic [7:0] exec_op;
  logic       halted;

  logic [7:0] mem [256];
  int         mem_wait = 0;
  int         wcnt = 0;
  logic       pc_set = 1'b0;
  logic [7:0] pc_set_val = 8'h00;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  pc_sequencer #(.STACK_DEPTH(4)) dut (
    .CLK(CLK), .CLB(CLB), .run(run), .pc_count(pc_count), .instr_in(instr_in),
    .mem_ack(mem_ack), .zero_flag(zero_flag), .mem_req(mem_req), .mem_addr(mem_addr),
    .SelPC(SelPC), .IncPC(IncPC), .LoadPC(LoadPC), .A(A), .B(B),
    .exec_valid(exec_valid), .exec_op(exec_op), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // PC_module model
  always @(posedge CLK) begin
    if (pc_set) pc_count <= pc_set_val;
    else if (IncPC) pc_count <= pc_count + 8'd1;
    else if (LoadPC) pc_count <= SelPC ? A : {4'h0, B};
  end

  // Memory: ack mem_wait cycles after the request is seen, single-cycle pulse.
  always @(negedge CLK) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (mem_req) begin
      if (wcnt == mem_wait) begin
        mem_ack  = 1'b1;
        instr_in = mem[mem_addr];
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset(input logic [7:0] pc0);
    run = 1'b0;
    zero_flag = 1'b0;
    CLB = 1'b0;
    pc_set = 1'b1;
    pc_set_val = pc0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    pc_set = 1'b0;
    CLB = 1'b1;
  endtask

  task automatic wait_load(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (LoadPC) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    run = 1'b1;
    CLB = 1'b0;
    pc_set = 1'b1;
    pc_set_val = 8'h00;
    repeat (2) cycle();
    total_cnt++;
    if ({mem_req, IncPC, LoadPC, SelPC, exec_valid, halted} !== 6'b0)
      $display("FAIL reset_strobes: got %b expected 000000",
               {mem_req, IncPC, LoadPC, SelPC, exec_valid, halted});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, A, B, exec_op} !== 28'h0)
      $display("FAIL reset_buses: got addr=%h A=%h B=%h op=%h expected all 0", mem_addr, A, B, exec_op);
    else pass_cnt++;
    @(negedge CLK);
    run = 1'b0;
    pc_set = 1'b0;
    CLB = 1'b1;
    repeat (3) cycle();
    total_cnt++;
    if (mem_req !== 1'b0) $display("FAIL idle_no_req: got %b expected 0", mem_req);
    else pass_cnt++;
  endtask

  task automatic test_nop_stream();
    logic [2:0] exp_s;
    clear_mem();
    do_reset(8'h00);
    run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      exp_s = {(c % 3 == 1), (c % 3 == 0), 1'b0};
      total_cnt++;
      if ({mem_req, IncPC, LoadPC} !== exp_s)
        $display("FAIL nop_strobes c%0d: got req/inc/load=%b expected %b", c, {mem_req, IncPC, LoadPC}, exp_s);
      else pass_cnt++;
      if (c % 3 == 1) begin
        total_cnt++;
        if (mem_addr !== 8'((c - 1) / 3))
          $display("FAIL nop_addr c%0d: got %h expected %h", c, mem_addr, 8'((c - 1) / 3));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_jmps();
    clear_mem();
    mem[8'h10] = 8'h27;
    do_reset(8'h10);
    run = 1'b1;
    cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h10})
      $display("FAIL jmps_fetch: got req=%b addr=%h expected 1/10", mem_req, mem_addr);
    else pass_cnt++;
    repeat (2) cycle();
    total_cnt++;
    if ({IncPC, LoadPC, SelPC, B} !== {1'b0, 1'b1, 1'b0, 4'h7})
      $display("FAIL jmps_exec: got inc=%b load=%b sel=%b B=%h expected 0/1/0/7", IncPC, LoadPC, SelPC, B);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h07})
      $display("FAIL jmps_next: got req=%b addr=%h expected 1/07", mem_req, mem_addr);
    else pass_cnt++;
  endtask

  task automatic test_jmp_wait();
    clear_mem();
    mem_wait = 3;
    mem[8'h30] = 8'h10;
    mem[8'h31] = 8'hA5;
    do_reset(8'h30);
    run = 1'b1;
    repeat (4) cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h30})
      $display("FAIL jmp_req_held: got req=%b addr=%h expected 1/30", mem_req, mem_addr);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({mem_req, IncPC, LoadPC} !== 3'b010)
      $display("FAIL jmp_decode: got req/inc/load=%b expected 010", {mem_req, IncPC, LoadPC});
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h31})
      $display("FAIL jmp_opnd: got req=%b addr=%h expected 1/31", mem_req, mem_addr);
    else pass_cnt++;
    repeat (4) cycle();
    total_cnt++;
    if ({IncPC, LoadPC, SelPC, A} !== {1'b0, 1'b1, 1'b1, 8'hA5})
      $display("FAIL jmp_exec: got inc=%b load=%b sel=%b A=%h expected 0/1/1/a5", IncPC, LoadPC, SelPC, A);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'hA5})
      $display("FAIL jmp_next: got req=%b addr=%h expected 1/a5", mem_req, mem_addr);
    else pass_cnt++;
    mem_wait = 0;
  endtask

  task automatic test_jmp_wrap();
    clear_mem();
    mem[8'hFF] = 8'h10;
    mem[8'h00] = 8'h3C;
    do_reset(8'hFF);
    run = 1'b1;
    repeat (3) cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h00})
      $display("FAIL wrap_opnd: got req=%b addr=%h expected 1/00", mem_req, mem_addr);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({LoadPC, SelPC, A} !== {1'b1, 1'b1, 8'h3C})
      $display("FAIL wrap_exec: got load=%b sel=%b A=%h expected 1/1/3c", LoadPC, SelPC, A);
    else pass_cnt++;
  endtask

  task automatic test_bz();
    clear_mem();
    mem[8'h50] = 8'h39;
    do_reset(8'h50);
    run = 1'b1;
    repeat (3) cycle();
    total_cnt++;
    if ({IncPC, LoadPC} !== 2'b10)
      $display("FAIL bz_not_taken: got inc/load=%b expected 10", {IncPC, LoadPC});
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h51})
      $display("FAIL bz_fallthrough: got req=%b addr=%h expected 1/51", mem_req, mem_addr);
    else pass_cnt++;
    do_reset(8'h50);
    zero_flag = 1'b1;
    run = 1'b1;
    repeat (3) cycle();
    zero_flag = 1'b0;
    #1;
    total_cnt++;
    if ({IncPC, LoadPC, SelPC, B} !== {1'b0, 1'b1, 1'b0, 4'h9})
      $display("FAIL bz_taken: got inc=%b load=%b sel=%b B=%h expected 0/1/0/9", IncPC, LoadPC, SelPC, B);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h09})
      $display("FAIL bz_target: got req=%b addr=%h expected 1/09", mem_req, mem_addr);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    clear_mem();
    mem[8'h60] = 8'hF0;
    do_reset(8'h60);
    run = 1'b1;
    repeat (2) cycle();
    total_cnt++;
    if ({IncPC, LoadPC, halted} !== 3'b000)
      $display("FAIL halt_decode: got inc/load/halted=%b expected 000", {IncPC, LoadPC, halted});
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({halted, mem_req} !== 2'b10)
      $display("FAIL halt_enter: got halted/req=%b expected 10", {halted, mem_req});
    else pass_cnt++;
    repeat (3) cycle();
    total_cnt++;
    if ({halted, mem_req, IncPC, LoadPC} !== 4'b1000)
      $display("FAIL halt_stay: got halted/req/inc/load=%b expected 1000", {halted, mem_req, IncPC, LoadPC});
    else pass_cnt++;
    run = 1'b0;
    cycle();
    total_cnt++;
    if ({halted, mem_req} !== 2'b00)
      $display("FAIL halt_exit: got halted/req=%b expected 00", {halted, mem_req});
    else pass_cnt++;
    run = 1'b1;
    cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h60})
      $display("FAIL halt_refetch: got req=%b addr=%h expected 1/60", mem_req, mem_addr);
    else pass_cnt++;
  endtask

  task automatic test_datapath_run_drop();
    clear_mem();
    mem[8'h70] = 8'h9C;
    do_reset(8'h70);
    run = 1'b1;
    repeat (2) cycle();
    run = 1'b0;
    cycle();
    total_cnt++;
    if ({IncPC, LoadPC, exec_valid, exec_op} !== {1'b1, 1'b0, 1'b1, 8'h9C})
      $display("FAIL dp_exec: got inc=%b load=%b valid=%b op=%h expected 1/0/1/9c", IncPC, LoadPC, exec_valid, exec_op);
    else pass_cnt++;
    repeat (3) cycle();
    total_cnt++;
    if ({mem_req, exec_valid, IncPC} !== 3'b000)
      $display("FAIL dp_stopped: got req/valid/inc=%b expected 000", {mem_req, exec_valid, IncPC});
    else pass_cnt++;
  endtask

`ifdef PC_SEQ_STACK_EN
  task automatic test_call_ret();
    logic [7:0] exp_a [10];
    bit seen;
    clear_mem();
    mem[8'h20] = 8'h40;
    mem[8'h21] = 8'h40;
    mem[8'h40] = 8'h50;
    do_reset(8'h20);
    run = 1'b1;
    repeat (4) cycle();
    total_cnt++;
    if ({LoadPC, SelPC, A} !== {1'b1, 1'b1, 8'h40})
      $display("FAIL call_exec: got load=%b sel=%b A=%h expected 1/1/40", LoadPC, SelPC, A);
    else pass_cnt++;
    repeat (3) cycle();
    total_cnt++;
    if ({LoadPC, SelPC, A} !== {1'b1, 1'b1, 8'h22})
      $display("FAIL ret_exec: got load=%b sel=%b A=%h expected 1/1/22", LoadPC, SelPC, A);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h22})
      $display("FAIL ret_next: got req=%b addr=%h expected 1/22", mem_req, mem_addr);
    else pass_cnt++;

    clear_mem();
    mem[8'h80] = 8'h40; mem[8'h81] = 8'h84;
    mem[8'h84] = 8'h40; mem[8'h85] = 8'h88;
    mem[8'h88] = 8'h40; mem[8'h89] = 8'h8C;
    mem[8'h8C] = 8'h40; mem[8'h8D] = 8'h90;
    mem[8'h90] = 8'h40; mem[8'h91] = 8'h94;
    mem[8'h94] = 8'h50; mem[8'h92] = 8'h50;
    mem[8'h8E] = 8'h50; mem[8'h8A] = 8'h50;
    mem[8'h86] = 8'h50;
    exp_a = '{8'h84, 8'h88, 8'h8C, 8'h90, 8'h94, 8'h92, 8'h8E, 8'h8A, 8'h86, 8'h00};
    do_reset(8'h80);
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_load(seen);
      total_cnt++;
      if (!seen || SelPC !== 1'b1 || A !== exp_a[i])
        $display("FAIL nest_load%0d: got seen=%b sel=%b A=%h expected 1/1/%h", i, seen, SelPC, A, exp_a[i]);
      else pass_cnt++;
    end
  endtask
`else
  task automatic test_call_ret();
    clear_mem();
    mem[8'h20] = 8'h4A;
    mem[8'h21] = 8'h55;
    do_reset(8'h20);
    run = 1'b1;
    repeat (3) cycle();
    total_cnt++;
    if ({IncPC, LoadPC} !== 2'b10)
      $display("FAIL call_nop: got inc/load=%b expected 10", {IncPC, LoadPC});
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h21})
      $display("FAIL call_nop_next: got req=%b addr=%h expected 1/21", mem_req, mem_addr);
    else pass_cnt++;
    repeat (2) cycle();
    total_cnt++;
    if ({IncPC, LoadPC} !== 2'b10)
      $display("FAIL ret_nop: got inc/load=%b expected 10", {IncPC, LoadPC});
    else pass_cnt++;
    cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h22})
      $display("FAIL ret_nop_next: got req=%b addr=%h expected 1/22", mem_req, mem_addr);
    else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid_opnd();
    clear_mem();
    mem_wait = 3;
    mem[8'h30] = 8'h10;
    mem[8'h31] = 8'hA5;
    do_reset(8'h30);
    run = 1'b1;
    repeat (6) cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h31})
      $display("FAIL mid_opnd_req: got req=%b addr=%h expected 1/31", mem_req, mem_addr);
    else pass_cnt++;
    #2;
    CLB = 1'b0;
    #1;
    total_cnt++;
    if ({mem_req, IncPC, LoadPC, SelPC, halted, exec_valid, mem_addr, A} !== 22'h0)
      $display("FAIL async_reset: got req=%b inc=%b load=%b sel=%b halted=%b valid=%b addr=%h A=%h expected all 0",
               mem_req, IncPC, LoadPC, SelPC, halted, exec_valid, mem_addr, A);
    else pass_cnt++;
    mem_wait = 0;
    @(posedge CLK);
    #2;
    CLB = 1'b1;
    cycle();
    total_cnt++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h31})
      $display("FAIL post_reset_fetch: got req=%b addr=%h expected 1/31", mem_req, mem_addr);
    else pass_cnt++;
    repeat (2) cycle();
    total_cnt++;
    if ({IncPC, LoadPC, exec_valid, exec_op} !== {1'b1, 1'b0, 1'b1, 8'hA5})
      $display("FAIL post_reset_exec: got inc=%b load=%b valid=%b op=%h expected 1/0/1/a5", IncPC, LoadPC, exec_valid, exec_op);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_nop_stream();
    test_jmps();
    test_jmp_wait();
    test_jmp_wrap();
    test_bz();
    test_halt();
    test_datapath_run_drop();
    test_call_ret();
    test_reset_mid_opnd();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
